// File: rtl/decode_stage.sv
// Registered MIPS decode stage: ID/EX pipeline register, load-use bubble insertion, EX flush.
// Optional stall counter output stall_cnt is built only when DECODE_PERF_EN is defined.
module decode_stage #(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] instr,
    input  logic [DWIDTH-1:0] pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [1:0]        out_ssel,
    output logic [DWIDTH-1:0] out_imm,
    output logic [4:0]        out_rs1_id,
    output logic [4:0]        out_rs2_id,
    output logic [4:0]        out_rdst_id,
    output logic              out_we_regfile,
    output logic              out_we_dmem,
    output logic              out_mem_read,
    output logic [2:0]        out_jump_type,
    output logic [DWIDTH-1:0] out_jump_addr,
    output logic [DWIDTH-1:0] out_pc
`ifdef DECODE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_JR    = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_UNDEF = 4'b1111;

    localparam logic [1:0] SSEL_RS2  = 2'b00;
    localparam logic [1:0] SSEL_IMM  = 2'b01;
    localparam logic [1:0] SSEL_LINK = 2'b10;
    localparam logic [1:0] SSEL_NONE = 2'b11;

    localparam logic [2:0] JT_NONE = 3'b000;
    localparam logic [2:0] JT_BEQ  = 3'b001;
    localparam logic [2:0] JT_J    = 3'b010;
    localparam logic [2:0] JT_JR   = 3'b011;

    localparam logic [DWIDTH-1:0] PC_HI_MASK = {{(DWIDTH-28){1'b1}}, 28'b0};

    if (DWIDTH < 32 || CNT_W < 1) begin : g_param_check
        $error("decode_stage: DWIDTH must be >= 32 and CNT_W >= 1");
    end

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd_f;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd_f   = instr[15:11];
    assign funct  = instr[5:0];

    logic [3:0]        dec_op;
    logic [1:0]        dec_ssel;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic [4:0]        dec_rd;
    logic              dec_we_rf;
    logic              dec_we_dm;
    logic              dec_mr;
    logic [2:0]        dec_jt;
    logic              dec_uses_rt;
    logic              dec_r_alu;
    logic [DWIDTH-1:0] dec_imm;
    logic [DWIDTH-1:0] dec_jaddr;

    always_comb begin
        dec_op      = OP_UNDEF;
        dec_ssel    = SSEL_NONE;
        dec_rs1     = 5'd0;
        dec_rs2     = 5'd0;
        dec_rd      = 5'd0;
        dec_we_rf   = 1'b0;
        dec_we_dm   = 1'b0;
        dec_mr      = 1'b0;
        dec_jt      = JT_NONE;
        dec_uses_rt = 1'b0;
        dec_r_alu   = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_uses_rt = (funct != 6'b001000);
                case (funct)
                    6'b100000: begin dec_op = OP_ADD; dec_r_alu = 1'b1; end
                    6'b100010: begin dec_op = OP_SUB; dec_r_alu = 1'b1; end
                    6'b100100: begin dec_op = OP_AND; dec_r_alu = 1'b1; end
                    6'b100101: begin dec_op = OP_OR;  dec_r_alu = 1'b1; end
                    6'b100111: begin dec_op = OP_NOR; dec_r_alu = 1'b1; end
                    6'b101010: begin dec_op = OP_SLT; dec_r_alu = 1'b1; end
                    6'b001000: begin
                        dec_op  = OP_JR;
                        dec_rs1 = rs;
                        dec_jt  = JT_JR;
                    end
                    default: ;
                endcase
                if (dec_r_alu) begin
                    dec_rs1   = rs;
                    dec_rs2   = rt;
                    dec_rd    = rd_f;
                    dec_ssel  = SSEL_RS2;
                    dec_we_rf = 1'b1;
                end
            end
            6'b001000, 6'b001010: begin
                dec_op    = (opcode == 6'b001000) ? OP_ADD : OP_SLT;
                dec_ssel  = SSEL_IMM;
                dec_rs1   = rs;
                dec_rd    = rt;
                dec_we_rf = 1'b1;
            end
            6'b100011: begin
                dec_op    = OP_ADD;
                dec_ssel  = SSEL_IMM;
                dec_rs1   = rs;
                dec_rd    = rt;
                dec_we_rf = 1'b1;
                dec_mr    = 1'b1;
            end
            6'b101011: begin
                dec_op      = OP_ADD;
                dec_ssel    = SSEL_IMM;
                dec_rs1     = rs;
                dec_rs2     = rt;
                dec_we_dm   = 1'b1;
                dec_uses_rt = 1'b1;
            end
            6'b000100: begin
                dec_op      = OP_SUB;
                dec_ssel    = SSEL_RS2;
                dec_rs1     = rs;
                dec_rs2     = rt;
                dec_jt      = JT_BEQ;
                dec_uses_rt = 1'b1;
            end
            6'b000010: dec_jt = JT_J;
            6'b000011: begin
                dec_op    = OP_ADD;
                dec_ssel  = SSEL_LINK;
                dec_rd    = 5'd31;
                dec_we_rf = 1'b1;
                dec_jt    = JT_J;
            end
            default: ;
        endcase
    end

    assign dec_imm   = {{(DWIDTH-16){instr[15]}}, instr[15:0]};
    // Jump region comes from pc+4, so a jump in the last slot of a 256MB region lands in the next one.
    assign dec_jaddr = (dec_jt == JT_J)
                     ? (((pc + DWIDTH'(4)) & PC_HI_MASK) | DWIDTH'({instr[25:0], 2'b00}))
                     : '0;

    logic              valid_q, valid_d;
    logic [3:0]        op_q;
    logic [1:0]        ssel_q;
    logic [DWIDTH-1:0] imm_q;
    logic [4:0]        rs1_q, rs2_q, rd_q;
    logic              we_rf_q, we_dm_q, mr_q;
    logic [2:0]        jt_q;
    logic [DWIDTH-1:0] jaddr_q;
    logic [DWIDTH-1:0] pc_q;
    logic              hazard;
    logic              load;

    assign hazard = valid_q & mr_q & (rd_q != 5'd0) &
                    ((rs == rd_q) | (dec_uses_rt & (rt == rd_q)));
    assign in_ready = flush | ((~valid_q | out_ready) & ~hazard);
    assign load     = in_valid & in_ready & ~flush;

    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (hazard & out_ready)
            valid_d = 1'b0;
        else if (in_valid & in_ready)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            op_q    <= OP_UNDEF;
            ssel_q  <= SSEL_NONE;
            imm_q   <= '0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            we_rf_q <= 1'b0;
            we_dm_q <= 1'b0;
            mr_q    <= 1'b0;
            jt_q    <= JT_NONE;
            jaddr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                op_q    <= dec_op;
                ssel_q  <= dec_ssel;
                imm_q   <= dec_imm;
                rs1_q   <= dec_rs1;
                rs2_q   <= dec_rs2;
                rd_q    <= dec_rd;
                we_rf_q <= dec_we_rf;
                we_dm_q <= dec_we_dm;
                mr_q    <= dec_mr;
                jt_q    <= dec_jt;
                jaddr_q <= dec_jaddr;
                pc_q    <= pc;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_op         = op_q;
    assign out_ssel       = ssel_q;
    assign out_imm        = imm_q;
    assign out_rs1_id     = rs1_q;
    assign out_rs2_id     = rs2_q;
    assign out_rdst_id    = rd_q;
    assign out_we_regfile = we_rf_q;
    assign out_we_dmem    = we_dm_q;
    assign out_mem_read   = mr_q;
    assign out_jump_type  = jt_q;
    assign out_jump_addr  = jaddr_q;
    assign out_pc         = pc_q;

`ifdef DECODE_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid & hazard & ~flush & ~(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: scoreboard of expected decode bundles, immediate-assertion checks.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [1:0]  out_ssel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1_id;
    logic [4:0]  out_rs2_id;
    logic [4:0]  out_rdst_id;
    logic        out_we_regfile;
    logic        out_we_dmem;
    logic        out_mem_read;
    logic [2:0]  out_jump_type;
    logic [31:0] out_jump_addr;
    logic [31:0] out_pc;
`ifdef DECODE_PERF_EN
    logic [15:0] stall_cnt;
`endif

    decode_stage #(.DWIDTH(32), .CNT_W(16)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr          (instr),
        .pc             (pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_op         (out_op),
        .out_ssel       (out_ssel),
        .out_imm        (out_imm),
        .out_rs1_id     (out_rs1_id),
        .out_rs2_id     (out_rs2_id),
        .out_rdst_id    (out_rdst_id),
        .out_we_regfile (out_we_regfile),
        .out_we_dmem    (out_we_dmem),
        .out_mem_read   (out_mem_read),
        .out_jump_type  (out_jump_type),
        .out_jump_addr  (out_jump_addr),
        .out_pc         (out_pc)
`ifdef DECODE_PERF_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  ssel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wr;
        logic        wd;
        logic        mr;
        logic [2:0]  jt;
        logic [31:0] imm;
        logic [31:0] ja;
        logic [31:0] pc;
    } bnd_t;

    bnd_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic bnd_t mk(logic [3:0] op, logic [1:0] ss, logic [4:0] r1, logic [4:0] r2,
                                logic [4:0] rd, logic wr, logic wd, logic mr, logic [2:0] jt,
                                logic [31:0] imm, logic [31:0] ja, logic [31:0] p);
        bnd_t b;
        b.op = op; b.ssel = ss; b.rs1 = r1; b.rs2 = r2; b.rd = rd;
        b.wr = wr; b.wd = wd; b.mr = mr; b.jt = jt;
        b.imm = imm; b.ja = ja; b.pc = p;
        return b;
    endfunction

    function automatic bnd_t obs();
        bnd_t b;
        b.op = out_op; b.ssel = out_ssel; b.rs1 = out_rs1_id; b.rs2 = out_rs2_id;
        b.rd = out_rdst_id; b.wr = out_we_regfile; b.wd = out_we_dmem; b.mr = out_mem_read;
        b.jt = out_jump_type; b.imm = out_imm; b.ja = out_jump_addr; b.pc = out_pc;
        return b;
    endfunction

    task automatic chk_b(input string tag, input bnd_t o, input bnd_t e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h required=%h", tag, o, e);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h required=%h", tag, o, e);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f);
        in_valid  = v;
        instr     = i;
        pc        = p;
        out_ready = r;
        flush     = f;
    endtask

    // e is the expected decode of the instruction currently driven; pushed only if the beat is taken.
    task automatic tick(input bnd_t e);
        bnd_t want;
        #1;
        if (out_valid && out_ready && !flush) begin
            chk_v("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                want = sb.pop_front();
                $display("txn pc=%h op=%b ssel=%b rs1=%0d rs2=%0d rd=%0d jt=%b ja=%h",
                         out_pc, out_op, out_ssel, out_rs1_id, out_rs2_id, out_rdst_id,
                         out_jump_type, out_jump_addr);
                chk_b("beat", obs(), want);
            end
        end
        if (in_valid && in_ready && !flush) sb.push_back(e);
        if (flush) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [31:0] I_ADD1 = 32'h00221820;
    localparam logic [31:0] I_LW1  = 32'h8C220004;
    localparam logic [31:0] I_ADD2 = 32'h00441820;
    localparam logic [31:0] I_LW0  = 32'h8C200000;
    localparam logic [31:0] I_ADD0 = 32'h00001820;
    localparam logic [31:0] I_SUB  = 32'h00A62022;
    localparam logic [31:0] I_OR   = 32'h00430825;
    localparam logic [31:0] I_AND  = 32'h00622024;

    bnd_t        rst_b;
    logic [31:0] tbl_ins [9];
    logic [31:0] tbl_pc  [9];
    bnd_t        tbl_exp [9];

    initial begin
        rst_b = mk(4'b1111, 2'b11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);

        tbl_ins[0] = 32'h0C000040; tbl_pc[0] = 32'h00400000;
        tbl_exp[0] = mk(4'b0010, 2'b10, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h100, 32'h00400000);
        tbl_ins[1] = 32'hACC50008; tbl_pc[1] = 32'h200;
        tbl_exp[1] = mk(4'b0010, 2'b01, 5'd6, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h8, 32'h0, 32'h200);
        tbl_ins[2] = 32'h1022FFFF; tbl_pc[2] = 32'h204;
        tbl_exp[2] = mk(4'b0110, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h204);
        tbl_ins[3] = 32'h03E00008; tbl_pc[3] = 32'h208;
        tbl_exp[3] = mk(4'b1000, 2'b11, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b011, 32'h8, 32'h0, 32'h208);
        tbl_ins[4] = 32'h08000100; tbl_pc[4] = 32'hF0000000;
        tbl_exp[4] = mk(4'b1111, 2'b11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h100, 32'hF0000400, 32'hF0000000);
        tbl_ins[5] = 32'hFC000000; tbl_pc[5] = 32'h20C;
        tbl_exp[5] = mk(4'b1111, 2'b11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h20C);
        tbl_ins[6] = 32'h2107FFFE; tbl_pc[6] = 32'h210;
        tbl_exp[6] = mk(4'b0010, 2'b01, 5'd8, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 32'hFFFFFFFE, 32'h0, 32'h210);
        tbl_ins[7] = 32'h28220005; tbl_pc[7] = 32'h214;
        tbl_exp[7] = mk(4'b0111, 2'b01, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000, 32'h5, 32'h0, 32'h214);
        tbl_ins[8] = 32'h014B4827; tbl_pc[8] = 32'h218;
        tbl_exp[8] = mk(4'b1100, 2'b00, 5'd10, 5'd11, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000, 32'h4827, 32'h0, 32'h218);

        // Reset state
        rstn = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk_b("reset_bundle", obs(), rst_b);
        chk_v("reset_valid", 32'(out_valid), 32'd0);
`ifdef DECODE_PERF_EN
        chk_v("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        rstn = 1'b1;

        // add $3,$1,$2 with one-cycle latency
        drv(1'b1, I_ADD1, 32'h100, 1'b1, 1'b0);
        tick(mk(4'b0010, 2'b00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1820, 32'h0, 32'h100));
        chk_v("latency_valid", 32'(out_valid), 32'd1);

        // lw $2,4($1) then dependent add $3,$2,$4: one bubble
        drv(1'b1, I_LW1, 32'h104, 1'b1, 1'b0);
        tick(mk(4'b0010, 2'b01, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 3'b000, 32'h4, 32'h0, 32'h104));
        drv(1'b1, I_ADD2, 32'h108, 1'b1, 1'b0);
        #1;
        chk_v("hazard_in_ready", 32'(in_ready), 32'd0);
        tick(mk(4'b0010, 2'b00, 5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1820, 32'h0, 32'h108));
        chk_v("bubble_valid", 32'(out_valid), 32'd0);
`ifdef DECODE_PERF_EN
        chk_v("stall_cnt_one", 32'(stall_cnt), 32'd1);
`endif
        tick(mk(4'b0010, 2'b00, 5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1820, 32'h0, 32'h108));
        chk_v("post_bubble_valid", 32'(out_valid), 32'd1);

        // lw $0 never creates a hazard
        drv(1'b1, I_LW0, 32'h10C, 1'b1, 1'b0);
        tick(mk(4'b0010, 2'b01, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h10C));
        drv(1'b1, I_ADD0, 32'h110, 1'b1, 1'b0);
        #1;
        chk_v("r0_in_ready", 32'(in_ready), 32'd1);
        tick(mk(4'b0010, 2'b00, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1820, 32'h0, 32'h110));
        chk_v("r0_no_bubble", 32'(out_valid), 32'd1);

        // Back-to-back decode table: jal, sw, beq, jr, j, undefined, addi, slti, nor
        for (int k = 0; k < 9; k++) begin
            drv(1'b1, tbl_ins[k], tbl_pc[k], 1'b1, 1'b0);
            tick(tbl_exp[k]);
        end

        // Backpressure: payload must hold for three cycles
        drv(1'b1, I_SUB, 32'h300, 1'b1, 1'b0);
        tick(mk(4'b0110, 2'b00, 5'd5, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000, 32'h2022, 32'h0, 32'h300));
        drv(1'b1, I_OR, 32'h304, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_v("stall_in_ready", 32'(in_ready), 32'd0);
            chk_v("stall_valid", 32'(out_valid), 32'd1);
            chk_b("stall_payload", obs(),
                  mk(4'b0110, 2'b00, 5'd5, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000, 32'h2022, 32'h0, 32'h300));
            tick(mk(4'b0001, 2'b00, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0825, 32'h0, 32'h304));
        end
        drv(1'b1, I_OR, 32'h304, 1'b1, 1'b0);
        tick(mk(4'b0001, 2'b00, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0825, 32'h0, 32'h304));
        chk_v("release_valid", 32'(out_valid), 32'd1);

        // Flush with a beat offered: it is discarded and the held payload untouched
        drv(1'b1, I_AND, 32'h308, 1'b0, 1'b1);
        #1;
        chk_v("flush_in_ready", 32'(in_ready), 32'd1);
        tick(mk(4'b0000, 2'b00, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000, 32'h2024, 32'h0, 32'h308));
        chk_v("flush_valid", 32'(out_valid), 32'd0);
        chk_b("flush_payload", obs(),
              mk(4'b0001, 2'b00, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0825, 32'h0, 32'h304));
        drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick(rst_b);
        chk_v("flush_discarded", 32'(out_valid), 32'd0);
        chk_v("sb_drained", 32'(sb.size()), 32'd0);

        // Reset asserted in the middle of a load-use stall
        drv(1'b1, I_LW1, 32'h400, 1'b1, 1'b0);
        tick(mk(4'b0010, 2'b01, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 3'b000, 32'h4, 32'h0, 32'h400));
        drv(1'b1, I_ADD2, 32'h404, 1'b0, 1'b0);
        tick(rst_b);
        tick(rst_b);
`ifdef DECODE_PERF_EN
        chk_v("stall_cnt_three", 32'(stall_cnt), 32'd3);
`endif
        rstn = 1'b0;
        #1;
        chk_b("midstall_reset_bundle", obs(), rst_b);
        chk_v("midstall_reset_valid", 32'(out_valid), 32'd0);
`ifdef DECODE_PERF_EN
        chk_v("midstall_reset_cnt", 32'(stall_cnt), 32'd0);
`endif
        sb.delete();
        rstn = 1'b1;

        // After reset the formerly stalled add is accepted at once
        drv(1'b1, I_ADD2, 32'h404, 1'b1, 1'b0);
        #1;
        chk_v("post_reset_in_ready", 32'(in_ready), 32'd1);
        tick(mk(4'b0010, 2'b00, 5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1820, 32'h0, 32'h404));
        chk_v("post_reset_valid", 32'(out_valid), 32'd1);
        drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick(rst_b);
        chk_v("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
